// File: rtl/klotski_move_recorder.sv
// rtl/klotski_move_recorder.sv - checks 4x4 klotski snapshots and queues blank-move directions
// Optional build macro KLOTSKI_REPLAY_EN turns the FIFO into a replayable record buffer.
module klotski_move_recorder #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [63:0]       i_klotski,
  input  logic              i_board_valid,
`ifdef KLOTSKI_REPLAY_EN
  input  logic              i_replay,
`endif
  output logic              o_busy,
  output logic [1:0]        o_dir,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_error,
  output logic              o_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_LOCATE, S_WAIT, S_DIFF} state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [63:0]       ref_r;
  logic [63:0]       snap_r;
  logic [3:0]        zpos_r;
  logic [3:0]        idx;
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [1:0]        mem [DEPTH];

  logic [4:0]        zcnt;
  logic [3:0]        nz;
  logic              found, adj, rest_ok, swap_ok, legal, same;
  logic [1:0]        dir_new;
  logic [1:0]        zr, zc, nr, nc;
  logic              push_req, push_ok, pop, overflow_set;

  assign o_count = wr_ptr - rd_ptr;
  assign o_valid = (o_count != '0);
  assign o_empty = ~o_valid;
`ifdef KLOTSKI_REPLAY_EN
  assign o_full  = (wr_ptr == DEPTH_W);
`else
  assign o_full  = (o_count == DEPTH_W);
`endif
  assign o_dir   = o_valid ? mem[rd_ptr[ADDR_W-1:0]] : 2'd0;
  assign o_busy  = (state == S_LOCATE) || (state == S_DIFF);

  // Move legality: exactly one blank, orthogonally adjacent, swapped tile matches, rest untouched.
  always_comb begin
    zcnt    = '0;
    nz      = '0;
    found   = 1'b0;
    rest_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (snap_r[i*4 +: 4] == 4'd0) begin
        zcnt = zcnt + 5'd1;
        if (!found) nz = 4'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < 16; i++) begin
      if ((4'(i) != zpos_r) && (4'(i) != nz) && (snap_r[i*4 +: 4] != ref_r[i*4 +: 4]))
        rest_ok = 1'b0;
    end
    zr      = zpos_r[3:2];
    zc      = zpos_r[1:0];
    nr      = nz[3:2];
    nc      = nz[1:0];
    adj     = 1'b1;
    dir_new = 2'd0;
    if (nc == zc && zr != 2'd0 && nr == zr - 2'd1)       dir_new = 2'd0;
    else if (nc == zc && zr != 2'd3 && nr == zr + 2'd1)  dir_new = 2'd1;
    else if (nr == zr && zc != 2'd0 && nc == zc - 2'd1)  dir_new = 2'd2;
    else if (nr == zr && zc != 2'd3 && nc == zc + 2'd1)  dir_new = 2'd3;
    else                                                 adj = 1'b0;
    swap_ok = (snap_r[{zpos_r, 2'b00} +: 4] == ref_r[{nz, 2'b00} +: 4]);
    legal   = (zcnt == 5'd1) && adj && swap_ok && rest_ok;
    same    = (snap_r == ref_r);
  end

  always_comb begin
    push_req = (state == S_DIFF) && !i_start && !same && legal;
    pop      = o_valid && i_ready;
`ifdef KLOTSKI_REPLAY_EN
    push_ok  = push_req && !o_full;
`else
    push_ok  = push_req && (!o_full || pop);
`endif
    overflow_set = push_req && !push_ok;
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr[ADDR_W-1:0]] <= dir_new;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      ref_r      <= '0;
      snap_r     <= '0;
      zpos_r     <= '0;
      idx        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_error    <= 1'b0;
      o_overflow <= 1'b0;
    end else if (i_start) begin
      ref_r      <= i_klotski;
      idx        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_error    <= 1'b0;
      o_overflow <= 1'b0;
      state      <= S_LOCATE;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
`ifdef KLOTSKI_REPLAY_EN
      if (i_replay) rd_ptr <= '0;
      else if (pop) rd_ptr <= rd_ptr + 1'b1;
`else
      if (pop) rd_ptr <= rd_ptr + 1'b1;
`endif
      if (overflow_set) o_overflow <= 1'b1;
      case (state)
        S_IDLE: ;
        S_LOCATE: begin
          if (ref_r[{idx, 2'b00} +: 4] == 4'd0) begin
            zpos_r <= idx;
            state  <= S_WAIT;
          end else if (idx == 4'd15) begin
            o_error <= 1'b1;
            state   <= S_IDLE;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        S_WAIT: begin
          if (i_board_valid) begin
            snap_r <= i_klotski;
            state  <= S_DIFF;
          end
        end
        S_DIFF: begin
          state <= S_WAIT;
          if (!same) begin
            if (legal) begin
              ref_r  <= snap_r;
              zpos_r <= nz;
            end else begin
              o_error <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_klotski_move_recorder.sv
// tb/tb_klotski_move_recorder.sv - scoreboard bench for klotski_move_recorder
module tb_klotski_move_recorder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] klotski;
  logic        board_valid;
  logic        busy;
  logic [1:0]  dir;
  logic        valid;
  logic        ready;
  logic [6:0]  count;
  logic        full, empty, error, overflow;
`ifdef KLOTSKI_REPLAY_EN
  logic        replay;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0]  sb[$];
  logic [63:0] cur;
  int          bp;

  always #5 clk = ~clk;

  klotski_move_recorder #(.DEPTH(64), .ADDR_W(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_klotski(klotski),
    .i_board_valid(board_valid),
`ifdef KLOTSKI_REPLAY_EN
    .i_replay(replay),
`endif
    .o_busy(busy), .o_dir(dir), .o_valid(valid), .i_ready(ready),
    .o_count(count), .o_full(full), .o_empty(empty), .o_error(error),
    .o_overflow(overflow)
  );

  function automatic logic [63:0] solved();
    logic [63:0] b;
    for (int i = 0; i < 15; i++) b[i*4 +: 4] = 4'(i + 1);
    b[63:60] = 4'd0;
    return b;
  endfunction

  function automatic logic [63:0] swap_cells(logic [63:0] b, int a, int c);
    logic [63:0] t;
    t = b;
    t[a*4 +: 4] = b[c*4 +: 4];
    t[c*4 +: 4] = b[a*4 +: 4];
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin tick(); n++; end
    if (busy) begin
      n_cmp++; n_bad++;
      $display("FAIL busy_timeout busy=%0b required 0", busy);
    end
  endtask

  task automatic start_board(input logic [63:0] b);
    start = 1'b1; klotski = b; tick(); start = 1'b0;
    wait_idle();
    cur = b;
    bp = 0;
    for (int i = 15; i >= 0; i--) if (b[i*4 +: 4] == 4'd0) bp = i;
  endtask

  task automatic send_snap(input logic [63:0] b);
    wait_idle();
    klotski = b; board_valid = 1'b1; tick(); board_valid = 1'b0; tick();
  endtask

  task automatic move(input int d, input bit push_exp);
    int t;
    logic [63:0] nb;
    t  = bp + ((d == 0) ? -4 : (d == 1) ? 4 : (d == 2) ? -1 : 1);
    nb = swap_cells(cur, bp, t);
    send_snap(nb);
    if (push_exp) sb.push_back(2'(d));
    cur = nb; bp = t;
  endtask

  task automatic drain();
    int guard = 0;
    logic [1:0] e;
    ready = 1'b1;
    while (sb.size() > 0 && guard < 200) begin
      if (valid) begin
        e = sb.pop_front();
        n_cmp++;
        if (dir !== e) begin n_bad++; $display("FAIL drain_dir got %0d required %0d", dir, e); end
      end
      tick(); guard++;
    end
    ready = 1'b0;
    n_cmp++;
    if (sb.size() != 0 || empty !== 1'b1) begin
      n_bad++; $display("FAIL drain_done left=%0d empty=%0b required 0/1", sb.size(), empty);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #3;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %0b required 1", empty); end
    n_cmp++; if ({busy, valid, full, error, overflow} !== 5'b0) begin
      n_bad++; $display("FAIL reset_flags got %b required 00000", {busy, valid, full, error, overflow}); end
    n_cmp++; if (count !== 7'd0 || dir !== 2'd0) begin
      n_bad++; $display("FAIL reset_count got %0d/%0d required 0/0", count, dir); end
    tick(); tick(); rst_n = 1'b1; tick();
  endtask

  task automatic test_locate();
    int n = 0;
    start = 1'b1; klotski = solved(); tick(); start = 1'b0;
    while (busy && n < 40) begin tick(); n++; end
    cur = solved(); bp = 15;
    n_cmp++; if (n != 16) begin n_bad++; $display("FAIL locate_cycles got %0d required 16", n); end
    n_cmp++; if (empty !== 1'b1 || error !== 1'b0) begin
      n_bad++; $display("FAIL locate_flags got empty=%0b error=%0b required 1/0", empty, error); end
  endtask

  task automatic test_legal_moves();
    logic [63:0] nb;
    nb = swap_cells(cur, 15, 14);
    klotski = nb; board_valid = 1'b1; tick(); board_valid = 1'b0;
    n_cmp++; if (valid !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL latency_n1 got valid=%0b busy=%0b required 0/1", valid, busy); end
    tick();
    n_cmp++; if (valid !== 1'b1 || dir !== 2'd2) begin
      n_bad++; $display("FAIL latency_n2 got valid=%0b dir=%0d required 1/2", valid, dir); end
    sb.push_back(2'd2);
    cur = nb; bp = 14;
    move(0, 1'b1);
    n_cmp++; if (count !== 7'd2) begin n_bad++; $display("FAIL legal_count got %0d required 2", count); end
    drain();
  endtask

  task automatic test_illegal();
    start_board(solved());
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL illegal_clear got %0b required 0", error); end
    send_snap(swap_cells(cur, 15, 13));
    n_cmp++; if (error !== 1'b1 || count !== 7'd0) begin
      n_bad++; $display("FAIL illegal_jump got err=%0b cnt=%0d required 1/0", error, count); end
    move(2, 1'b1);
    n_cmp++; if (count !== 7'd1 || error !== 1'b1) begin
      n_bad++; $display("FAIL illegal_recover got cnt=%0d err=%0b required 1/1", count, error); end
    drain();
  endtask

  task automatic test_same_and_wrap();
    start_board(solved());
    send_snap(solved());
    n_cmp++; if (error !== 1'b0 || count !== 7'd0) begin
      n_bad++; $display("FAIL same_board got err=%0b cnt=%0d required 0/0", error, count); end
    start_board(swap_cells(solved(), 11, 15));
    send_snap(swap_cells(cur, 11, 12));
    n_cmp++; if (error !== 1'b1 || count !== 7'd0) begin
      n_bad++; $display("FAIL row_wrap got err=%0b cnt=%0d required 1/0", error, count); end
  endtask

  task automatic test_overflow();
    logic [63:0] nb;
    logic [1:0]  e;
    start_board(solved());
    for (int k = 0; k < 64; k++) move((k % 2 == 0) ? 2 : 3, 1'b1);
    n_cmp++; if (count !== 7'd64 || full !== 1'b1 || overflow !== 1'b0) begin
      n_bad++; $display("FAIL fill got cnt=%0d full=%0b ovf=%0b required 64/1/0", count, full, overflow); end
    move(2, 1'b0);
    n_cmp++; if (overflow !== 1'b1 || count !== 7'd64) begin
      n_bad++; $display("FAIL overflow got ovf=%0b cnt=%0d required 1/64", overflow, count); end
    nb = swap_cells(cur, bp, bp + 1);
    wait_idle();
    klotski = nb; board_valid = 1'b1; tick(); board_valid = 1'b0;
    ready = 1'b1;
    e = sb.pop_front();
    n_cmp++; if (valid !== 1'b1 || dir !== e) begin
      n_bad++; $display("FAIL full_pop got valid=%0b dir=%0d required 1/%0d", valid, dir, e); end
    sb.push_back(2'd3);
    tick(); ready = 1'b0;
    cur = nb; bp = bp + 1;
    n_cmp++; if (count !== 7'd64) begin n_bad++; $display("FAIL full_push_pop got %0d required 64", count); end
    drain();
  endtask

`ifdef KLOTSKI_REPLAY_EN
  task automatic test_replay();
    logic [1:0] rec[$];
    start_board(solved());
    move(2, 1'b1); move(0, 1'b1); move(3, 1'b1);
    rec = sb;
    drain();
    replay = 1'b1; tick(); replay = 1'b0;
    n_cmp++; if (count !== 7'd3) begin n_bad++; $display("FAIL replay_count got %0d required 3", count); end
    sb = rec;
    drain();
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; klotski = '0; board_valid = 1'b0; ready = 1'b0;
`ifdef KLOTSKI_REPLAY_EN
    replay = 1'b0;
`endif
    test_reset();
    test_locate();
    test_legal_moves();
    test_illegal();
    test_same_and_wrap();
    test_overflow();
`ifdef KLOTSKI_REPLAY_EN
    test_replay();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/klotski_move_recorder.md
Name: klotski_move_recorder

Overview:
- Consumer of successive 4x4 klotski board snapshots from the blank-tile mover.
- Each legal snapshot must differ from the previous one by one orthogonal blank move.
- Derives the blank-tile direction of each step and queues it in a FIFO.
- Downstream consumers (display animation, UART dump) read directions through a valid/ready handshake.

Parameters:
DEPTH, 64, FIFO entries; power of 2, >= 4
ADDR_W, 6, log2(DEPTH)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset, asynchronous, active-low
i_start  input  1  pulse: latch i_klotski as initial board, clear FIFO and flags; honoured in any state
i_klotski  input  64  board; cell (r,c) = bits [(4r+c)*4+3 : (4r+c)*4]; nibble 0 = blank
i_board_valid  input  1  snapshot strobe; sampled only in S_WAIT
o_busy  output  1  high in S_LOCATE and S_DIFF; snapshots ignored while high
o_dir  output  2  head direction of blank: 0=UP 1=DOWN 2=LEFT 3=RIGHT
o_valid  output  1  FIFO not empty
i_ready  input  1  pop when o_valid & i_ready
o_count  output  ADDR_W+1  entries held
o_full  output  1  o_count == DEPTH
o_empty  output  1  o_count == 0
o_error  output  1  sticky: illegal snapshot or no blank found
o_overflow  output  1  sticky: legal move dropped because FIFO full

Behaviour:
- Reset values: all outputs 0, except o_empty=1. State S_IDLE; ref board 0; pointers 0.
- Asynchronous reset is legal mid-operation and returns every register to its reset value.
- States:
  - S_IDLE: on i_start, ref_r <= i_klotski; clear FIFO, o_error, o_overflow; idx <= 0; go S_LOCATE.
  - S_LOCATE: examine ref_r cell idx, one cell per cycle, idx 0..15.
    - First zero nibble: zpos_r <= {r,c}; go S_WAIT.
    - idx==15 with no zero: set o_error; go S_IDLE.
    - Latency 1..16 cycles.
  - S_WAIT: on i_board_valid, snap_r <= i_klotski; go S_DIFF.
  - S_DIFF: single-cycle evaluation (see legality below); always returns to S_WAIT.
- i_start in any non-idle state aborts the current operation, reloads and restarts exactly as from S_IDLE. A pending S_DIFF result is discarded.
- Legality in S_DIFF:
  - Let nz = lowest cell index of snap_r holding 0.
  - Legal when snap_r contains exactly one zero, nz is one orthogonal neighbour of zpos_r (no wrap across rows), snap_r[zpos_r] == ref_r[nz], and all other 14 cells are equal.
  - Direction from row/column delta of nz relative to zpos_r: row-1 -> UP, row+1 -> DOWN, col-1 -> LEFT, col+1 -> RIGHT.
- S_DIFF outcomes:
  - snap_r == ref_r: dropped silently; no flag, ref unchanged.
  - Legal: ref_r <= snap_r, zpos_r <= nz, push direction.
    - If full and no pop this cycle: direction dropped, o_overflow set, ref still updated.
  - Illegal: o_error set; ref_r and zpos_r unchanged; snapshot discarded.
- Latency: snapshot accepted at cycle N; evaluated at N+1; o_valid / o_dir reflect the push at N+2 if the FIFO was empty.
- FIFO:
  - Circular; rd/wr pointers are ADDR_W+1 bits with MSB wrap bit.
  - o_dir = mem[rd]; first-word-fall-through.
  - Simultaneous push and pop:
    - Full: push accepted, count unchanged.
    - Empty: pop ignored (o_valid=0), push accepted.
  - i_ready while empty: no effect.

Optional Feature:
KLOTSKI_REPLAY_EN
- Defined:
  - Adds input i_replay (1 bit) and turns the FIFO into a record buffer.
  - wr never wraps; full when wr == DEPTH.
  - Pop advances rd without freeing entries.
  - i_replay pulse sets rd <= 0 so the whole recording is re-emitted.
  - o_count = wr - rd.
  - i_start clears wr and rd.
  - i_replay together with a pop: i_replay wins.
- Undefined: port absent; circular FIFO as above.

Test Plan:
- Reset, then i_start with solved board (cells 0..14 = 1..15, cell 15 = 0) -> S_LOCATE takes 16 cycles, o_busy falls, o_empty=1, o_error=0.
- From solved board, snapshot with cell14=0, cell15=15 at cycle N -> o_valid=1, o_dir=2 (LEFT) at N+2; then snapshot with cell10=0, cell14=11 -> second entry o_dir=0 (UP); o_count=2.
- Illegal snapshot (blank jumps cell15 -> cell13) -> o_error=1, o_count unchanged; following legal move from old blank position still accepted.
- Snapshot with zero at cell 12 while blank at cell 11 (row-wrap neighbour) -> rejected, o_error=1.
- Fill DEPTH=64 moves with i_ready=0, push a 65th -> o_overflow=1, o_count=64; repeat with i_ready=1 on the push cycle -> push accepted, count stays 64.
- KLOTSKI_REPLAY_EN: record 3 moves, pop all 3 (o_empty=1), pulse i_replay -> o_count=3, o_dir sequence repeats identically.
